sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
Two-master, one-slave Avalon-MM arbiter that shares the single SDRAM port (avalon_if_sdram, 32-bit) between the video stream reader (master 0) and a frame-buffer writer (master 1). Sits in Top between the requesters and hw_support. Single-word transfers only. At most one transaction is outstanding at a time. Round-robin fairness is the default.

Parameters:
ADDR_W, 32, address width on all ports
DATA_BYTES, 4, data bus bytes; data width = 8*DATA_BYTES

Ports:
sys_clk  in  1  system clock, 100 MHz
sys_rst  in  1  reset, asynchronous, active-high
m0_address / m1_address  in  ADDR_W  master address
m0_read / m1_read  in  1  read request
m0_write / m1_write  in  1  write request
m0_writedata / m1_writedata  in  8*DATA_BYTES  write data
m0_byteenable / m1_byteenable  in  DATA_BYTES  byte lanes
m0_waitrequest / m1_waitrequest  out  1  stall to master
m0_readdata / m1_readdata  out  8*DATA_BYTES  read data
m0_readdatavalid / m1_readdatavalid  out  1  read data strobe
s_address  out  ADDR_W  to SDRAM
s_read, s_write  out  1  to SDRAM
s_writedata  out  8*DATA_BYTES  to SDRAM
s_byteenable  out  DATA_BYTES  to SDRAM
s_waitrequest  in  1  from SDRAM
s_readdata  in  8*DATA_BYTES  from SDRAM
s_readdatavalid  in  1  from SDRAM
grant  out  2  one-hot current owner, status/debug

Behaviour:
- Reset is sys_rst, asynchronous, active-high; clock is sys_clk.
- Reset values: state=IDLE, grant=0, last=1 (so master 0 wins the first tie), and s_read, s_write, s_address, s_writedata, s_byteenable all 0.
- Master waitrequest: mN_waitrequest=1 except in GRANT when owner is N and s_waitrequest=0. Masters are held off during IDLE and WAIT_RD.
- Requests: reqN = mN_read | mN_write. read&write asserted together is illegal. The arbiter treats it as a read. The assertion below flags it.
- FSM states:
  - IDLE: if any reqN, pick owner and go to GRANT on the next edge. Arbitration latency is 1 cycle. The slave sees no command in IDLE.
  - Pick rule in IDLE: only one requesting -> that master. Both requesting -> the master != last.
  - GRANT: slave outputs combinationally mux the owner's signals. Stay while s_waitrequest=1.
  - Exit from GRANT: when s_waitrequest=0, the transfer is accepted and last<=owner. A write goes to IDLE. A read goes to WAIT_RD.
  - WAIT_RD: slave command outputs are 0. On s_readdatavalid=1, go to IDLE and clear grant.
- Read data: s_readdata is broadcast to both mN_readdata. mN_readdatavalid = s_readdatavalid & (owner==N) & state==WAIT_RD. A readdatavalid in the same cycle as acceptance (zero-latency slave) is also forwarded, and the FSM then goes directly to IDLE.
- Throughput: minimum 2 cycles per write (IDLE + GRANT). A read takes 2 cycles + slave latency. There is no back-to-back grant without passing through IDLE.
- If a master drops its request while in GRANT (protocol violation), the arbiter keeps driving its latched address/data and completes the transfer. For this, command fields are registered at grant time, not muxed live.
- Reset mid-transfer: the FSM returns to IDLE immediately. A read response arriving after reset is ignored.
- grant equals the one-hot owner in GRANT/WAIT_RD, else 0.
- Simulation assertion (SIMULATION defined): error if mN_read&mN_write are both set, or if s_readdatavalid is seen outside WAIT_RD/GRANT.

Optional Feature:
SDRAM_ARB_FIXED_PRIO_EN: when defined, master 0 (video) always wins a tie regardless of last. Master 1 is served only when master 0 is idle, since video underrun is worse than a slow writer. When undefined, ties use round-robin as above.

Test Plan:
- Single write from m1: addr=0x100, data=0xDEADBEEF, be=0xF, s_waitrequest held 3 cycles -> s_write seen on 4 consecutive cycles with exact fields; m1_waitrequest low in exactly 1 cycle; grant=2'b10.
- Single read from m0, slave latency 5 cycles returning 0x12345678 -> m0_readdatavalid pulses once with that value; m1_readdatavalid stays 0.
- Both masters request continuously, 8 writes each -> grants alternate m0,m1,m0,... starting with m0. With SDRAM_ARB_FIXED_PRIO_EN defined, all 8 m0 writes complete before any m1 write.
- Read by m0 in WAIT_RD while m1 requests -> no s_write is issued until after readdatavalid; m1 is granted on the cycle after the IDLE that follows.
- sys_rst asserted during WAIT_RD, with the late readdatavalid arriving afterwards -> all outputs return to 0 immediately; the late response produces no mN_readdatavalid.
- m0 deasserts read mid-GRANT -> the slave still sees the original address until s_waitrequest=0; the FSM reaches WAIT_RD.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Single-word Avalon-MM port bundle shared by the arbiter's master-facing and SDRAM-facing sides.
// The master modport issues commands; the slave modport answers with waitrequest and read data.
interface sdram_arbiter_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_BYTES = 4
);
    logic [ADDR_W-1:0]       address;
    logic                    read;
    logic                    write;
    logic [8*DATA_BYTES-1:0] writedata;
    logic [DATA_BYTES-1:0]   byteenable;
    logic                    waitrequest;
    logic [8*DATA_BYTES-1:0] readdata;
    logic                    readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-master round-robin arbiter for the single SDRAM Avalon-MM port, one transfer in flight.
// Define SDRAM_ARB_FIXED_PRIO_EN to let master 0 (video) win every tie.
module sdram_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    sdram_arbiter_if.slave   m0,
    sdram_arbiter_if.slave   m1,
    sdram_arbiter_if.master  s,
    output logic [1:0]       grant
);
    localparam int unsigned DW = 8 * DATA_BYTES;

    typedef enum logic [1:0] {StIdle, StGrant, StWaitRd} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  is_rd_q, is_rd_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [DATA_BYTES-1:0] be_q, be_d;

    logic req0, req1, pick, in_grant, accept, rd_fwd;

    assign req0     = m0.read | m0.write;
    assign req1     = m1.read | m1.write;
    assign in_grant = (state_q == StGrant);
    assign accept   = in_grant & ~s.waitrequest;

    always_comb begin
        pick = ~req0;
        if (req0 && req1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            pick = 1'b0;
`else
            pick = ~last_q;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        is_rd_d = is_rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // Latch the winner's command so a master dropping out mid-grant can't corrupt it.
                    state_d = StGrant;
                    owner_d = pick;
                    is_rd_d = pick ? m1.read : m0.read;
                    addr_d  = pick ? m1.address : m0.address;
                    wdata_d = pick ? m1.writedata : m0.writedata;
                    be_d    = pick ? m1.byteenable : m0.byteenable;
                end
            end
            StGrant: begin
                if (accept) begin
                    last_d  = owner_q;
                    state_d = (is_rd_q && !s.readdatavalid) ? StWaitRd : StIdle;
                end
            end
            StWaitRd: begin
                if (s.readdatavalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            is_rd_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            is_rd_q <= is_rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign s.address    = in_grant ? addr_q : '0;
    assign s.writedata  = in_grant ? wdata_q : '0;
    assign s.byteenable = in_grant ? be_q : '0;
    assign s.read       = in_grant & is_rd_q;
    assign s.write      = in_grant & ~is_rd_q;

    assign grant = (state_q == StIdle) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

    assign m0.waitrequest = ~(accept & ~owner_q);
    assign m1.waitrequest = ~(accept & owner_q);

    // Zero-latency slaves return data in the accept cycle itself.
    assign rd_fwd = s.readdatavalid & ((state_q == StWaitRd) | (accept & is_rd_q));

    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;
    assign m0.readdatavalid = rd_fwd & ~owner_q;
    assign m1.readdatavalid = rd_fwd & owner_q;

`ifdef SIMULATION
    a_m0_rw: assert property (@(posedge sys_clk) disable iff (sys_rst) !(m0.read && m0.write))
        else $error("m0 asserted read and write together");
    a_m1_rw: assert property (@(posedge sys_clk) disable iff (sys_rst) !(m1.read && m1.write))
        else $error("m1 asserted read and write together");
    a_rdv: assert property (@(posedge sys_clk) disable iff (sys_rst)
        s.readdatavalid |-> (state_q inside {StGrant, StWaitRd}))
        else $error("SDRAM readdatavalid with no read outstanding");
`endif
endmodule
